if_id_reg: RTL and testbench

IF_ID_REG -- requirements
Module: if_id_reg

---
 rtl/mips_pkg.sv | 22 ++
 rtl/if_id_reg_if.sv | 29 ++
 rtl/if_addr_chk.sv | 19 +
 rtl/if_id_reg.sv | 93 +++++++++
 tb/tb_if_id_reg.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types: fetch window, reset PC,
// exception codes and the IF/ID register update actions.
package mips_pkg;

  localparam logic [31:0] PC_RESET    = 32'h0000_3000;
  localparam logic [31:0] IM_BASE     = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT    = 32'h0000_6FFC;
  localparam logic [31:0] LINK_OFFSET = 32'd8;
  localparam logic [15:0] STALL_MAX   = 16'hFFFF;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t EXC_NONE = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_HOLD,
    UPD_FLUSH
  } upd_e;

endpackage

// File: rtl/if_id_reg_if.sv
// IF/ID pipeline bus: fetch-side request fields and the registered ID-side view.
interface if_id_reg_if;
  import mips_pkg::*;

  logic        en;
  logic        flush;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic        bd_if;

  logic [31:0] pc_id;
  logic [31:0] pc8_id;
  logic [31:0] instr_id;
  logic        bd_id;
  logic        valid_id;
  exc_code_t   exc_id;
  logic [15:0] stall_cnt;

  modport master (
    output en, flush, pc_if, instr_if, bd_if,
    input  pc_id, pc8_id, instr_id, bd_id, valid_id, exc_id, stall_cnt
  );

  modport slave (
    input  en, flush, pc_if, instr_if, bd_if,
    output pc_id, pc8_id, instr_id, bd_id, valid_id, exc_id, stall_cnt
  );

endinterface

// File: rtl/if_addr_chk.sv
// Fetch address legality check, shared with the exception unit.
// Misaligned or out-of-window addresses raise AdEL.
module if_addr_chk #(
  parameter logic [31:0] IM_BASE  = mips_pkg::IM_BASE,
  parameter logic [31:0] IM_LIMIT = mips_pkg::IM_LIMIT
) (
  input  logic [31:0]          pc,
  output mips_pkg::exc_code_t  exc
);
  import mips_pkg::*;

  always_comb begin
    exc = EXC_NONE;
    if ((pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT)) begin
      exc = EXC_ADEL;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall/flush control, fetch address
// exception tagging and a saturating stall-cycle counter.
module if_id_reg #(
  parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
  parameter logic [31:0] IM_BASE  = mips_pkg::IM_BASE,
  parameter logic [31:0] IM_LIMIT = mips_pkg::IM_LIMIT
) (
  input  logic         clk,
  input  logic         reset,
  if_id_reg_if.slave   bus
);
  import mips_pkg::*;

  upd_e        upd;
  exc_code_t   fetch_exc;

  logic [31:0] pc_q;
  logic [31:0] pc8_q;
  logic [31:0] instr_q;
  logic        bd_q;
  logic        valid_q;
  exc_code_t   exc_q;
  logic [15:0] stall_q;

  if_addr_chk #(
    .IM_BASE  (IM_BASE),
    .IM_LIMIT (IM_LIMIT)
  ) u_addr_chk (
    .pc  (bus.pc_if),
    .exc (fetch_exc)
  );

  // Flush outranks the hazard unit's stall so a squashed slot never lingers.
  always_comb begin
    upd = UPD_LOAD;
    if (bus.flush) begin
      upd = UPD_FLUSH;
    end else if (!bus.en) begin
      upd = UPD_HOLD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= PC_RESET;
      pc8_q   <= PC_RESET + LINK_OFFSET;
      instr_q <= 32'h0000_0000;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
      exc_q   <= EXC_NONE;
    end else begin
      case (upd)
        UPD_FLUSH: begin
          // The PC still follows IF so EPC stays meaningful for a bubble.
          pc_q    <= bus.pc_if;
          pc8_q   <= bus.pc_if + LINK_OFFSET;
          instr_q <= 32'h0000_0000;
          bd_q    <= 1'b0;
          valid_q <= 1'b0;
          exc_q   <= EXC_NONE;
        end
        UPD_LOAD: begin
          pc_q    <= bus.pc_if;
          pc8_q   <= bus.pc_if + LINK_OFFSET;
          instr_q <= (fetch_exc != EXC_NONE) ? 32'h0000_0000 : bus.instr_if;
          bd_q    <= bus.bd_if;
          valid_q <= 1'b1;
          exc_q   <= fetch_exc;
        end
        default: begin
        end
      endcase
    end
  end

  // Only stalls that freeze a real instruction are counted; reset alone clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'h0000;
    end else if ((upd == UPD_HOLD) && valid_q && (stall_q != STALL_MAX)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.pc_id     = pc_q;
  assign bus.pc8_id    = pc8_q;
  assign bus.instr_id  = instr_q;
  assign bus.bd_id     = bd_q;
  assign bus.valid_id  = valid_q;
  assign bus.exc_id    = exc_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed vector table, randomized
// traffic against a behavioural model, counter saturation and async reset.
module tb_if_id_reg;
  import mips_pkg::*;

  logic clk;
  logic reset;

  if_id_reg_if bus();

  if_id_reg #(
    .PC_RESET (32'h0000_3000),
    .IM_BASE  (32'h0000_3000),
    .IM_LIMIT (32'h0000_6FFC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_bd;
    logic        exp_valid;
    logic [4:0]  exp_exc;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vecs[$];

  int passed = 0;
  int total  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_bd;
  logic        m_valid;
  logic [4:0]  m_exc;
  int          m_stall;

  function automatic vec_t mk_vec(logic en, logic flush, logic [31:0] pc, logic [31:0] instr,
                                  logic bd, logic [31:0] e_pc, logic [31:0] e_instr, logic e_bd,
                                  logic e_valid, logic [4:0] e_exc, logic [15:0] e_stall);
    vec_t v;
    v.en = en; v.flush = flush; v.pc = pc; v.instr = instr; v.bd = bd;
    v.exp_pc = e_pc; v.exp_instr = e_instr; v.exp_bd = e_bd;
    v.exp_valid = e_valid; v.exp_exc = e_exc; v.exp_stall = e_stall;
    return v;
  endfunction

  function automatic logic [4:0] spec_exc(logic [31:0] pc);
    if ((pc % 4) != 0 || pc < 32'h0000_3000 || pc > 32'h0000_6FFC) return 5'd4;
    return 5'd0;
  endfunction

  function automatic logic [31:0] rand_pc();
    int unsigned kind;
    kind = $urandom_range(0, 9);
    case (kind)
      0:       return 32'h0000_3000 + 32'($urandom_range(0, 4095) * 4) + 32'($urandom_range(1, 3));
      1:       return 32'($urandom_range(0, 32'h2FFF));
      2:       return 32'h0000_7000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
      3:       return 32'h0000_6FFC;
      4:       return 32'h0000_7000;
      default: return 32'h0000_3000 + 32'($urandom_range(0, 4095) * 4);
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = 32'h0; m_bd = 1'b0;
    m_valid = 1'b0; m_exc = 5'd0; m_stall = 0;
  endtask

  task automatic model_step(logic en, logic flush, logic [31:0] pc, logic [31:0] instr, logic bd);
    if (flush) begin
      m_pc = pc; m_instr = 32'h0; m_valid = 1'b0; m_exc = 5'd0; m_bd = 1'b0;
    end else if (!en) begin
      if (m_valid && m_stall < 65535) m_stall = m_stall + 1;
    end else begin
      m_pc    = pc;
      m_bd    = bd;
      m_valid = 1'b1;
      m_exc   = spec_exc(pc);
      m_instr = (m_exc != 5'd0) ? 32'h0 : instr;
    end
  endtask

  task automatic apply_stimulus(logic en, logic flush, logic [31:0] pc, logic [31:0] instr, logic bd);
    @(negedge clk);
    bus.en = en; bus.flush = flush; bus.pc_if = pc; bus.instr_if = instr; bus.bd_if = bd;
    model_step(en, flush, pc, instr, bd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    else passed++;
  endtask

  task automatic check_model(string tag);
    check_output({tag, ".pc_id"},     bus.pc_id,            m_pc);
    check_output({tag, ".pc8_id"},    bus.pc8_id,           m_pc + 32'd8);
    check_output({tag, ".instr_id"},  bus.instr_id,         m_instr);
    check_output({tag, ".bd_id"},     32'(bus.bd_id),       32'(m_bd));
    check_output({tag, ".valid_id"},  32'(bus.valid_id),    32'(m_valid));
    check_output({tag, ".exc_id"},    32'(bus.exc_id),      32'(m_exc));
    check_output({tag, ".stall_cnt"}, 32'(bus.stall_cnt),   32'(m_stall));
  endtask

  task automatic check_reset(string tag);
    check_output({tag, ".pc_id"},     bus.pc_id,          32'h0000_3000);
    check_output({tag, ".pc8_id"},    bus.pc8_id,         32'h0000_3008);
    check_output({tag, ".instr_id"},  bus.instr_id,       32'h0);
    check_output({tag, ".bd_id"},     32'(bus.bd_id),     32'h0);
    check_output({tag, ".valid_id"},  32'(bus.valid_id),  32'h0);
    check_output({tag, ".exc_id"},    32'(bus.exc_id),    32'h0);
    check_output({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'h0);
  endtask

  initial begin
    // Directed sequence from reset: load, 3-cycle stall, flush over stall,
    // fetch exceptions, window edges, flush beating en, wrap of pc8.
    vecs.push_back(mk_vec(1, 0, 32'h3004, 32'h2408_0001, 0, 32'h3004, 32'h2408_0001, 0, 1, 0, 0));
    vecs.push_back(mk_vec(0, 0, 32'h3100, 32'hDEAD_BEEF, 1, 32'h3004, 32'h2408_0001, 0, 1, 0, 1));
    vecs.push_back(mk_vec(0, 0, 32'h3200, 32'h1111_1111, 0, 32'h3004, 32'h2408_0001, 0, 1, 0, 2));
    vecs.push_back(mk_vec(0, 0, 32'h3300, 32'h2222_2222, 1, 32'h3004, 32'h2408_0001, 0, 1, 0, 3));
    vecs.push_back(mk_vec(0, 1, 32'h3010, 32'h0000_ABCD, 1, 32'h3010, 32'h0, 0, 0, 0, 3));
    vecs.push_back(mk_vec(0, 0, 32'h3020, 32'h3333_3333, 1, 32'h3010, 32'h0, 0, 0, 0, 3));
    vecs.push_back(mk_vec(1, 0, 32'h3002, 32'h1234_5678, 1, 32'h3002, 32'h0, 1, 1, 4, 3));
    vecs.push_back(mk_vec(1, 0, 32'h7000, 32'h8765_4321, 0, 32'h7000, 32'h0, 0, 1, 4, 3));
    vecs.push_back(mk_vec(1, 0, 32'h6FFC, 32'hCAFE_F00D, 1, 32'h6FFC, 32'hCAFE_F00D, 1, 1, 0, 3));
    vecs.push_back(mk_vec(1, 0, 32'h2FFC, 32'h0000_0001, 0, 32'h2FFC, 32'h0, 0, 1, 4, 3));
    vecs.push_back(mk_vec(1, 1, 32'h3000, 32'h0000_0005, 1, 32'h3000, 32'h0, 0, 0, 0, 3));
    vecs.push_back(mk_vec(1, 0, 32'h3000, 32'h0000_0005, 0, 32'h3000, 32'h0000_0005, 0, 1, 0, 3));
    vecs.push_back(mk_vec(0, 0, 32'h4000, 32'h0000_0006, 1, 32'h3000, 32'h0000_0005, 0, 1, 0, 4));
    vecs.push_back(mk_vec(1, 0, 32'hFFFF_FFFC, 32'h0000_0009, 1, 32'hFFFF_FFFC, 32'h0, 1, 1, 4, 4));

    reset = 1'b1;
    bus.en = 1'b0; bus.flush = 1'b0; bus.pc_if = 32'h0; bus.instr_if = 32'h0; bus.bd_if = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) reset = 1'b1;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply_stimulus(vecs[i].en, vecs[i].flush, vecs[i].pc, vecs[i].instr, vecs[i].bd);
      check_output({t, ".pc_id"},     bus.pc_id,          vecs[i].exp_pc);
      check_output({t, ".pc8_id"},    bus.pc8_id,         vecs[i].exp_pc + 32'd8);
      check_output({t, ".instr_id"},  bus.instr_id,       vecs[i].exp_instr);
      check_output({t, ".bd_id"},     32'(bus.bd_id),     32'(vecs[i].exp_bd));
      check_output({t, ".valid_id"},  32'(bus.valid_id),  32'(vecs[i].exp_valid));
      check_output({t, ".exc_id"},    32'(bus.exc_id),    32'(vecs[i].exp_exc));
      check_output({t, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(vecs[i].exp_stall));
    end

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                     rand_pc(), $urandom, 1'($urandom_range(0, 1)));
      check_model($sformatf("rand%0d", i));
    end

    // Long stall on a valid instruction drives the counter into saturation.
    apply_stimulus(1'b1, 1'b0, 32'h0000_3040, 32'h2409_0002, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      apply_stimulus(1'b0, 1'b0, rand_pc(), $urandom, 1'($urandom_range(0, 1)));
    end
    check_model("sat");
    check_output("sat.stall_cnt_max", 32'(bus.stall_cnt), 32'h0000_FFFF);

    // Reset dropped between edges with a flush pending must act at once.
    @(negedge clk);
    bus.en = 1'b0; bus.flush = 1'b1; bus.pc_if = 32'h0000_5000;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset("async_reset");
    @(posedge clk);
    #1 check_reset("reset_held");

    @(negedge clk);
    bus.en = 1'b1; bus.flush = 1'b0; bus.pc_if = 32'h0000_3008;
    bus.instr_if = 32'h240A_0003; bus.bd_if = 1'b1;
    reset = 1'b1;
    model_reset();
    model_step(1'b1, 1'b0, 32'h0000_3008, 32'h240A_0003, 1'b1);
    @(posedge clk);
    #1 check_model("post_reset_load");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
